updown_sweep_ctrl: RTL and testbench
====================================

# updown_sweep_ctrl

Sequencer for the team's W-bit up/down counter (control encoding 00 hold, 01 increment, 10 decrement). It takes a start command with a window [limit_lo, limit_hi] and a sweep mode. It then drives the counter's control lines, reading the counter value back, to produce an up ramp, a down ramp, or a repeated triangle, and signals completion. It sits between user/test logic and one counter instance.

## Interface
- W, 8, counter width; must match the driven counter.
- clk  in  1  rising-edge clock shared with the counter.
- reset  in  1  synchronous, active-high; clears all state at the next rising edge.
- start  in  1  command strobe; honoured only in IDLE.
- mode  in  2  00 up ramp, 01 down ramp, 10 triangle, 11 reserved.
- limit_lo  in  W  lower window bound, unsigned.
- limit_hi  in  W  upper window bound, unsigned.
- cycles  in  4  number of triangles for mode 10 (1–15).
- hold  in  1  pause; forces control=00 without a state change.
- abort  in  1  terminates the run with no done pulse.
- count_val  in  W  counter output, fed back.
- control  out  2  to counter control; combinational from state, latched config and count_val.
- busy  out  1  high in SEEK, UP, DOWN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse when a start is rejected.
- sweep_cnt  out  4  triangles completed in the current or last run.

## Operation
- **States:** IDLE, SEEK, UP, DOWN, DONE. Reset gives IDLE with control=00, busy=0, done=0, err=0, sweep_cnt=0, and latched config cleared.
- **IDLE:** control=00. On start:
  - Reject if mode==11, if limit_lo>limit_hi, or if mode==10 with cycles==0. A rejection gives err=1 for the next cycle and the block stays in IDLE.
  - Otherwise latch mode, lo, hi and cycles, clear sweep_cnt, and go to SEEK.
  - Limit inputs are ignored after latching.
- **SEEK:** target = hi for mode 01, otherwise lo.
  - control = 01 if count_val<target, 10 if count_val>target, 00 if equal.
  - When equal, next state is UP for modes 00 and 10, DOWN for mode 01.
- **UP:** control=01 while count_val!=hi.
  - When count_val==hi, control=00. Next state is DONE for mode 00, DOWN for mode 10.
- **DOWN:** control=10 while count_val!=lo.
  - When count_val==lo, control=00.
  - Mode 01: next state is DONE.
  - Mode 10: sweep_cnt increments; next state is DONE if sweep_cnt+1==cycles, else UP.
- **DONE:** control=00, done=1 for exactly this cycle, then IDLE. sweep_cnt holds until the next accepted start.
- **hold=1 in SEEK, UP or DOWN:** control=00, and state, sweep_cnt and the transition decision are frozen. Comparisons resume when hold drops.
- **abort=1 in SEEK, UP, DOWN or DONE:** control=00 in that cycle, next state IDLE, no done.
  - abort beats hold.
  - abort in the DONE cycle does not suppress that cycle's done pulse.
- **start while busy:** ignored; no err.
- **Simultaneous start and abort in IDLE:** start wins.
- **lo==hi:** legal. Every phase reaches its endpoint immediately and spends one cycle with control=00.
- **Arithmetic:** all comparisons are unsigned W-bit. The block never commands a step past lo or hi during UP/DOWN, so the counter never wraps under this block's control.

## Timing
- start is sampled at edge k. The state is SEEK from cycle k+1, and busy rises in cycle k+1.
- The counter applies control at the edge ending the cycle in which it is asserted.
- Each endpoint costs one cycle with control=00 (the equality cycle) before the next phase begins.
- Cycle counts, with no hold applied:
  - Ramp from lo to hi: (hi−lo) cycles of 01 plus 1 cycle of 00.
  - Seek: |count_val−target| cycles plus 1.
  - Triangle: 2·(hi−lo+1) cycles.
- done is asserted in the cycle after the final equality cycle. busy is 0 in the DONE cycle.
- Reset asserted mid-run: IDLE at the next edge, control=00 combinationally from that edge; counter contents are not touched.

## Test plan
- **Up ramp:** counter=0, lo=3, hi=6, mode=00, start.
  - Required: control=01 for 3 cycles, 00 for 1 cycle, 01 for 3 cycles, 00 for 1 cycle.
  - Then done=1 with count_val=6; busy high for exactly 8 cycles.
- **Triangle:** counter=5, lo=2, hi=4, mode=10, cycles=2.
  - Required: seek down 3 cycles, +1 equality cycle; then UP/DOWN/UP/DOWN.
  - sweep_cnt goes 1 then 2; done after the second DOWN with count_val=2.
- **Rejected starts:** start with lo=9, hi=4; start with mode=11; start with mode=10 and cycles=0.
  - Required: err pulses one cycle each time, busy stays 0, control=00.
- **Hold:** hold for 4 cycles mid-UP at count_val=4 (lo=0, hi=8).
  - Required: control=00 and count_val=4 throughout the hold; ramp resumes afterwards; total run length +4.
- **Abort and busy start:** abort in DOWN at count_val=7.
  - Required: control=00 that cycle, IDLE next, no done, count_val stays 7.
  - start pulsed during busy has no effect.
- **Reset:** synchronous reset mid-triangle.
  - Required: next cycle state IDLE, control=00, sweep_cnt=0, done=0.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for an external up/down counter (00 hold, 01 inc, 10 dec).
// Produces up ramps, down ramps or repeated triangles inside [lo, hi].
module updown_sweep_ctrl #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [1:0]   i_mode,
    input  logic [W-1:0] i_limit_lo,
    input  logic [W-1:0] i_limit_hi,
    input  logic [3:0]   i_cycles,
    input  logic         i_hold,
    input  logic         i_abort,
    input  logic [W-1:0] i_count_val,
    output logic [1:0]   o_control,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [3:0]   o_sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [1:0] CTL_HOLD = 2'b00;
    localparam logic [1:0] CTL_INC  = 2'b01;
    localparam logic [1:0] CTL_DEC  = 2'b10;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_TRI  = 2'b10;
    localparam logic [1:0] M_RSVD = 2'b11;

    state_t       r_state;
    logic [1:0]   r_mode;
    logic [W-1:0] r_lo;
    logic [W-1:0] r_hi;
    logic [3:0]   r_cycles;
    logic [3:0]   r_sweep_cnt;
    logic         r_err;

    state_t       w_next;
    logic [1:0]   w_control;
    logic         w_accept;
    logic         w_reject;
    logic         w_bad_cfg;
    logic         w_sweep_inc;
    logic [W-1:0] w_target;
    logic [3:0]   w_sweep_nxt;

    assign w_bad_cfg = (i_mode == M_RSVD) ||
                       (i_limit_lo > i_limit_hi) ||
                       ((i_mode == M_TRI) && (i_cycles == 4'd0));

    assign w_target    = (r_mode == M_DOWN) ? r_hi : r_lo;
    assign w_sweep_nxt = r_sweep_cnt + 4'd1;

    always_comb begin
        w_next      = r_state;
        w_control   = CTL_HOLD;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_sweep_inc = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_bad_cfg) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = S_SEEK;
                    end
                end
            end
            S_SEEK: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (!i_hold) begin
                    if (i_count_val < w_target) begin
                        w_control = CTL_INC;
                    end else if (i_count_val > w_target) begin
                        w_control = CTL_DEC;
                    end else begin
                        w_next = (r_mode == M_DOWN) ? S_DOWN : S_UP;
                    end
                end
            end
            S_UP: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (!i_hold) begin
                    if (i_count_val != r_hi) begin
                        w_control = CTL_INC;
                    end else begin
                        w_next = (r_mode == M_TRI) ? S_DOWN : S_DONE;
                    end
                end
            end
            S_DOWN: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (!i_hold) begin
                    if (i_count_val != r_lo) begin
                        w_control = CTL_DEC;
                    end else if (r_mode == M_TRI) begin
                        w_sweep_inc = 1'b1;
                        w_next = (w_sweep_nxt == r_cycles) ? S_DONE : S_UP;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_mode      <= M_UP;
            r_lo        <= '0;
            r_hi        <= '0;
            r_cycles    <= '0;
            r_sweep_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject;
            if (w_accept) begin
                r_mode      <= i_mode;
                r_lo        <= i_limit_lo;
                r_hi        <= i_limit_hi;
                r_cycles    <= i_cycles;
                r_sweep_cnt <= '0;
            end else if (w_sweep_inc) begin
                r_sweep_cnt <= w_sweep_nxt;
            end
        end
    end

    assign o_control   = w_control;
    assign o_busy      = (r_state == S_SEEK) ||
                         (r_state == S_UP) ||
                         (r_state == S_DOWN);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = r_err;
    assign o_sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl driving a behavioural counter.
// Each run queues its expected end-of-run record; a monitor pops on events.
module tb_updown_sweep_ctrl;

    localparam int W = 8;
    localparam int K_DONE  = 0;
    localparam int K_ABORT = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int kind;
        int cnt;
        int sw;
        int bc;
        int n01;
        int n10;
        int n00;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] limit_lo;
    logic [W-1:0] limit_hi;
    logic [3:0]   cycles;
    logic         hold;
    logic         abort;
    logic [W-1:0] count_val;
    logic [1:0]   control;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   sweep_cnt;

    logic         ld;
    logic [W-1:0] ld_val;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;
    bit   prev_busy = 0;
    int   bc = 0;
    int   n01 = 0;
    int   n10 = 0;
    int   n00 = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(.W(W)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_mode      (mode),
        .i_limit_lo  (limit_lo),
        .i_limit_hi  (limit_hi),
        .i_cycles    (cycles),
        .i_hold      (hold),
        .i_abort     (abort),
        .i_count_val (count_val),
        .o_control   (control),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_sweep_cnt (sweep_cnt)
    );

    // behavioural model of the driven up/down counter
    always @(posedge clk) begin
        if (ld)
            count_val <= ld_val;
        else if (control == 2'b01)
            count_val <= count_val + 8'd1;
        else if (control == 2'b10)
            count_val <= count_val - 8'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic handle(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t",
                     kind, $time);
        end else begin
            e = q.pop_front();
            chk("kind", kind, e.kind);
            chk("control_at_event", int'(control), 0);
            if (kind == K_ERR) begin
                chk("busy_at_err", int'(busy), 0);
            end else begin
                chk("count_val", int'(count_val), e.cnt);
                chk("sweep_cnt", int'(sweep_cnt), e.sw);
                chk("busy_cycles", bc, e.bc);
                chk("ctl01_cycles", n01, e.n01);
                chk("ctl10_cycles", n10, e.n10);
                chk("ctl00_cycles", n00, e.n00);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (busy) begin
                    bc++;
                    if (control == 2'b01) n01++;
                    else if (control == 2'b10) n10++;
                    else n00++;
                end
                if (err)
                    handle(K_ERR);
                if (prev_busy && !busy) begin
                    handle(done ? K_DONE : K_ABORT);
                    bc  = 0;
                    n01 = 0;
                    n10 = 0;
                    n00 = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic push(input int k, input int c, input int s, input int b,
                        input int a01, input int a10, input int a00);
        exp_t e;
        e.kind = k;
        e.cnt  = c;
        e.sw   = s;
        e.bc   = b;
        e.n01  = a01;
        e.n10  = a10;
        e.n00  = a00;
        q.push_back(e);
    endtask

    task automatic preload(input logic [W-1:0] v);
        ld     = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld     = 1'b0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic [3:0] c);
        mode     = m;
        limit_lo = lo;
        limit_hi = hi;
        cycles   = c;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int k = 0;
        while (q.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cnt(input int v, input int sw, input int lim);
        int k = 0;
        while (!(int'(count_val) == v && int'(sweep_cnt) == sw) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (k >= lim) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout: got count %0d expected %0d",
                     count_val, v);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'b00;
        limit_lo = '0;
        limit_hi = '0;
        cycles   = '0;
        hold     = 1'b0;
        abort    = 1'b0;
        ld       = 1'b1;
        ld_val   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ld    = 1'b0;
        #2;
        chk("reset_control", int'(control), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_sweep", int'(sweep_cnt), 0);
        mon_en = 1;
        @(negedge clk);

        // up ramp: seek 0->3, ramp 3->6
        preload(8'd0);
        push(K_DONE, 6, 0, 8, 6, 0, 2);
        issue(2'b00, 8'd3, 8'd6, 4'd0);
        wait_drain(100);

        // triangle x2 from counter 5 in [2,4]
        preload(8'd5);
        push(K_DONE, 2, 2, 16, 4, 7, 5);
        issue(2'b10, 8'd2, 8'd4, 4'd2);
        wait_drain(100);

        // rejected starts
        push(K_ERR, 0, 0, 0, 0, 0, 0);
        issue(2'b00, 8'd9, 8'd4, 4'd0);
        wait_drain(10);
        push(K_ERR, 0, 0, 0, 0, 0, 0);
        issue(2'b11, 8'd0, 8'd5, 4'd0);
        wait_drain(10);
        push(K_ERR, 0, 0, 0, 0, 0, 0);
        issue(2'b10, 8'd0, 8'd5, 4'd0);
        wait_drain(10);

        // hold for 4 cycles mid-ramp at count 4
        preload(8'd0);
        push(K_DONE, 8, 0, 14, 8, 0, 6);
        issue(2'b00, 8'd0, 8'd8, 4'd0);
        wait_cnt(4, 0, 50);
        hold = 1'b1;
        repeat (4) @(negedge clk);
        hold = 1'b0;
        wait_drain(100);

        // down ramp aborted at 7, with an ignored start while busy
        preload(8'd9);
        push(K_ABORT, 7, 0, 4, 0, 2, 2);
        issue(2'b01, 8'd2, 8'd9, 4'd0);
        wait_cnt(8, 0, 50);
        issue(2'b11, 8'd9, 8'd4, 4'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_drain(100);

        // lo == hi triangle x2
        preload(8'd5);
        push(K_DONE, 5, 2, 5, 0, 0, 5);
        issue(2'b10, 8'd5, 8'd5, 4'd2);
        wait_drain(100);

        // full down ramp with seek down from 25
        preload(8'd25);
        push(K_DONE, 10, 0, 17, 0, 15, 2);
        issue(2'b01, 8'd10, 8'd20, 4'd0);
        wait_drain(100);

        // up ramp ending at the top of the range
        preload(8'd200);
        push(K_DONE, 255, 0, 57, 55, 0, 2);
        issue(2'b00, 8'd250, 8'd255, 4'd0);
        wait_drain(200);

        // synchronous reset mid-triangle
        preload(8'd0);
        push(K_ABORT, 4, 0, 17, 9, 5, 3);
        issue(2'b10, 8'd0, 8'd5, 4'd3);
        wait_cnt(3, 1, 100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
